pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage MIPS pipeline (F, D, E, M, W).
- Produces per-stage Stall*/Flush* for all pipeline registers, including the IF/ID register, which clears only on Flush & !Stall.
- Sequences PC redirects for taken branches whose delay slot is still being fetched over AXI, for exceptions/eret that must wait out an uncancellable fetch, and for the multi-cycle divider.

Parameters:
EXC_VECTOR, 32'hbfc00380, exception entry PC
DIV_CYCLES, 36, divider latency in cycles (>=2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
IfBusy  in  1  instruction fetch outstanding (no data yet)
IfDone  in  1  fetch data returned this cycle
MemBusy  in  1  data access outstanding in M
LoadUseD  in  1  load-use hazard detected for instruction in D
BranchD  in  1  branch/jump in D
PCSrcD  in  1  branch in D taken
BranchTargetD  in  32  target of branch in D
DivStartE  in  1  div/divu in E, first cycle
ExceptM  in  1  exception raised by instruction in M
EretM  in  1  eret in M
EpcM  in  32  CP0 EPC
StallF, StallD, StallE, StallM, StallW  out  1 each  hold stage register
FlushD, FlushE, FlushM, FlushW  out  1 each  clear stage register (bubble)
RedirectValid  out  1  load RedirectPC into PC this cycle
RedirectPC  out  32  redirect target
DivBusy  out  1  divider sequence active
CtrlState  out  2  current FSM state (debug)

Behaviour:
- Reset (async, reset=1): state RUN, div counter 0, saved target 0. All outputs 0, RedirectPC 0, CtrlState 0.
- Outputs are combinational from state and inputs. State, counter and saved target are registered.
- Invariant: FlushX and StallX are never both 1 for the same stage.

States: RUN=0, SLOT_WAIT=1, EXC_DRAIN=2, DIV=3.

Priority within a cycle: ExceptM|EretM > MemBusy > DIV state > LoadUseD > taken branch.

Exception/eret (any state):
- FlushD, FlushE, FlushM, FlushW = 1; all stalls = 0.
- Target = EXC_VECTOR if ExceptM, else EpcM. ExceptM wins if both are set.
- If IfBusy=0: RedirectValid=1 and RedirectPC=target this cycle; next state RUN.
- If IfBusy=1: save target, StallF=1, next state EXC_DRAIN.
- Any div counter or pending branch is discarded.

EXC_DRAIN:
- StallF=1; FlushD=1 every cycle.
- On IfDone: RedirectValid=1, RedirectPC=saved target, StallF=0, next state RUN.

MemBusy=1 (RUN or SLOT_WAIT):
- StallF/D/E/M=1, FlushW=1.
- Branch capture is suppressed. In DIV state the div counter still decrements.

DivStartE in RUN:
- Load counter with DIV_CYCLES-1, next state DIV.
- That cycle: StallF/D/E=1, FlushM=1, DivBusy=1.

DIV:
- Same outputs as above.
- Counter decrements each cycle. When it reaches 0, next state RUN; DivBusy is 0 in RUN.
- Total stall cycles = DIV_CYCLES.

LoadUseD (RUN only): StallF=1, StallD=1, FlushE=1. A branch in D is not captured that cycle.

Taken branch (RUN, BranchD & PCSrcD, StallD=0):
- No flush; the delay slot executes.
- If IfBusy=0: RedirectValid=1, RedirectPC=BranchTargetD this cycle.
- Else: save target, next state SLOT_WAIT.

SLOT_WAIT:
- StallD=1, FlushE=1 until the delay slot arrives.
- On IfDone: RedirectValid=1, RedirectPC=saved target, next state RUN.

Test Plan:
- Reset mid-DIV (counter=10) -> next cycle state RUN, DivBusy=0, all Stall/Flush=0, RedirectPC=0.
- DivStartE=1 at cycle 0, DIV_CYCLES=36 -> StallE=1, DivBusy=1 for cycles 0..35; StallE=0 at cycle 36.
- Taken branch, BranchTargetD=0xbfc00100, IfBusy=1 for 3 cycles then IfDone -> state 1 for 3 cycles; RedirectValid=1, RedirectPC=0xbfc00100 only on the IfDone cycle; FlushD never 1.
- ExceptM=1 with IfBusy=1 for 2 cycles -> FlushD/E/M/W=1, StallF=1, state 2; on IfDone, RedirectPC=0xbfc00380 with RedirectValid=1, then state 0.
- EretM=1, EpcM=0x80001234, IfBusy=0 -> same-cycle RedirectValid=1, RedirectPC=0x80001234; all four flushes=1.
- LoadUseD=1 together with MemBusy=1 -> StallF/D/E/M=1, FlushW=1, FlushE=0; with MemBusy=0 -> StallF=StallD=1, FlushE=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use, memory wait, divider
// sequencing, branch delay-slot redirects and exception/eret redirects.
module pipe_hazard_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hbfc00380,
    parameter int          DIV_CYCLES = 36
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        IfBusy,
    input  logic        IfDone,
    input  logic        MemBusy,
    input  logic        LoadUseD,
    input  logic        BranchD,
    input  logic        PCSrcD,
    input  logic [31:0] BranchTargetD,
    input  logic        DivStartE,
    input  logic        ExceptM,
    input  logic        EretM,
    input  logic [31:0] EpcM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        StallW,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        FlushW,
    output logic        RedirectValid,
    output logic [31:0] RedirectPC,
    output logic        DivBusy,
    output logic [1:0]  CtrlState
);

    localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SLOT_WAIT = 2'd1,
        EXC_DRAIN = 2'd2,
        DIV       = 2'd3
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   div_cnt, div_cnt_next;
    logic [31:0]        saved_pc, saved_pc_next;
    logic [31:0]        exc_target;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            div_cnt  <= '0;
            saved_pc <= '0;
        end else begin
            state    <= state_next;
            div_cnt  <= div_cnt_next;
            saved_pc <= saved_pc_next;
        end
    end

    assign CtrlState  = state;
    assign exc_target = ExceptM ? EXC_VECTOR : EpcM;

    always_comb begin
        StallF        = 1'b0;
        StallD        = 1'b0;
        StallE        = 1'b0;
        StallM        = 1'b0;
        StallW        = 1'b0;
        FlushD        = 1'b0;
        FlushE        = 1'b0;
        FlushM        = 1'b0;
        FlushW        = 1'b0;
        RedirectValid = 1'b0;
        RedirectPC    = '0;
        DivBusy       = 1'b0;
        state_next    = state;
        div_cnt_next  = div_cnt;
        saved_pc_next = saved_pc;

        if (ExceptM || EretM) begin
            // Exceptions override everything and discard any divide or pending branch.
            FlushD       = 1'b1;
            FlushE       = 1'b1;
            FlushM       = 1'b1;
            FlushW       = 1'b1;
            div_cnt_next = '0;
            if (!IfBusy) begin
                RedirectValid = 1'b1;
                RedirectPC    = exc_target;
                state_next    = RUN;
            end else begin
                StallF        = 1'b1;
                saved_pc_next = exc_target;
                state_next    = EXC_DRAIN;
            end
        end else begin
            case (state)
                EXC_DRAIN: begin
                    StallF = 1'b1;
                    FlushD = 1'b1;
                    if (IfDone) begin
                        StallF        = 1'b0;
                        RedirectValid = 1'b1;
                        RedirectPC    = saved_pc;
                        state_next    = RUN;
                    end
                end
                DIV: begin
                    DivBusy      = 1'b1;
                    StallF       = 1'b1;
                    StallD       = 1'b1;
                    StallE       = 1'b1;
                    div_cnt_next = (div_cnt == '0) ? '0 : div_cnt - 1'b1;
                    if (div_cnt <= CNT_W'(1))
                        state_next = RUN;
                    if (MemBusy) begin
                        StallM = 1'b1;
                        FlushW = 1'b1;
                    end else begin
                        FlushM = 1'b1;
                    end
                end
                SLOT_WAIT: begin
                    if (MemBusy) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        StallM = 1'b1;
                        FlushW = 1'b1;
                    end else if (!IfDone) begin
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                    // The delay slot has landed: the PC may now jump to the saved target.
                    if (IfDone) begin
                        RedirectValid = 1'b1;
                        RedirectPC    = saved_pc;
                        state_next    = RUN;
                    end
                end
                default: begin
                    if (MemBusy) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        StallM = 1'b1;
                        FlushW = 1'b1;
                    end else if (DivStartE) begin
                        StallF       = 1'b1;
                        StallD       = 1'b1;
                        StallE       = 1'b1;
                        FlushM       = 1'b1;
                        DivBusy      = 1'b1;
                        div_cnt_next = CNT_W'(DIV_CYCLES - 1);
                        state_next   = DIV;
                    end else if (LoadUseD) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end else if (BranchD && PCSrcD) begin
                        if (!IfBusy) begin
                            RedirectValid = 1'b1;
                            RedirectPC    = BranchTargetD;
                        end else begin
                            saved_pc_next = BranchTargetD;
                            state_next    = SLOT_WAIT;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus hand-written
// divider and reset sequences, all checked through an expected-value queue.
module tb_pipe_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        IfBusy, IfDone, MemBusy, LoadUseD, BranchD, PCSrcD, DivStartE, ExceptM, EretM;
    logic [31:0] BranchTargetD, EpcM;
    logic        StallF, StallD, StallE, StallM, StallW;
    logic        FlushD, FlushE, FlushM, FlushW;
    logic        RedirectValid, DivBusy;
    logic [31:0] RedirectPC;
    logic [1:0]  CtrlState;
    logic [12:0] act;

    always #5 clock = ~clock;

    pipe_hazard_ctrl dut (
        .clock(clock), .reset(reset),
        .IfBusy(IfBusy), .IfDone(IfDone), .MemBusy(MemBusy), .LoadUseD(LoadUseD),
        .BranchD(BranchD), .PCSrcD(PCSrcD), .BranchTargetD(BranchTargetD),
        .DivStartE(DivStartE), .ExceptM(ExceptM), .EretM(EretM), .EpcM(EpcM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .RedirectValid(RedirectValid), .RedirectPC(RedirectPC),
        .DivBusy(DivBusy), .CtrlState(CtrlState)
    );

    assign act = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, FlushM, FlushW,
                  RedirectValid, DivBusy, CtrlState};

    localparam logic [12:0] SF = 13'h1000, SD = 13'h0800, SE = 13'h0400, SM = 13'h0200;
    localparam logic [12:0] FD = 13'h0080, FE = 13'h0040, FM = 13'h0020, FW = 13'h0010;
    localparam logic [12:0] RV = 13'h0008, DB = 13'h0004, S1 = 13'h0001, S2 = 13'h0002, S3 = 13'h0003;
    localparam logic [8:0]  I_IB = 9'h001, I_ID = 9'h002, I_MB = 9'h004, I_LU = 9'h008;
    localparam logic [8:0]  I_BR = 9'h010, I_PS = 9'h020, I_DS = 9'h040, I_EX = 9'h080, I_ER = 9'h100;

    typedef struct {
        string       name;
        logic [8:0]  in;
        logic [31:0] tgt;
        logic [31:0] epc;
        logic [12:0] exp;
        logic [31:0] pc;
    } vec_t;

    typedef struct {
        string       name;
        logic [12:0] exp;
        logic [31:0] pc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mkv(input string n, input logic [8:0] i, input logic [31:0] t,
                                 input logic [31:0] e, input logic [12:0] x, input logic [31:0] p);
        vec_t v;
        v.name = n; v.in = i; v.tgt = t; v.epc = e; v.exp = x; v.pc = p;
        return v;
    endfunction

    task automatic set_inputs(input logic [8:0] i, input logic [31:0] t, input logic [31:0] e);
        IfBusy    = i[0];
        IfDone    = i[1];
        MemBusy   = i[2];
        LoadUseD  = i[3];
        BranchD   = i[4];
        PCSrcD    = i[5];
        DivStartE = i[6];
        ExceptM   = i[7];
        EretM     = i[8];
        BranchTargetD = t;
        EpcM          = e;
    endtask

    task automatic push_exp(input string n, input logic [12:0] x, input logic [31:0] p);
        exp_t r;
        r.name = n; r.exp = x; r.pc = p;
        sb.push_back(r);
    endtask

    task automatic check_out();
        exp_t r;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            r = sb.pop_front();
            if (act !== r.exp) begin
                errors++;
                $display("FAIL %s ctrl got %h expected %h", r.name, act, r.exp);
            end
            checks++;
            if (RedirectPC !== r.pc) begin
                errors++;
                $display("FAIL %s RedirectPC got %h expected %h", r.name, RedirectPC, r.pc);
            end
        end
    endtask

    // Inputs change just after a rising edge; outputs are checked at the falling edge.
    task automatic step(input string n, input logic [8:0] i, input logic [31:0] t,
                        input logic [31:0] e, input logic [12:0] x, input logic [31:0] p);
        set_inputs(i, t, e);
        push_exp(n, x, p);
        @(negedge clock);
        check_out();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(mkv("idle",          9'h0,                 32'h0,        32'h0,        13'h0,                   32'h0));
        vecs.push_back(mkv("lu_membusy",    I_LU | I_MB,          32'h0,        32'h0,        SF | SD | SE | SM | FW,  32'h0));
        vecs.push_back(mkv("loaduse",       I_LU,                 32'h0,        32'h0,        SF | SD | FE,            32'h0));
        vecs.push_back(mkv("eret_now",      I_ER,                 32'h0,        32'h80001234, FD | FE | FM | FW | RV,  32'h80001234));
        vecs.push_back(mkv("exc_eret_both", I_EX | I_ER,          32'h0,        32'h22222222, FD | FE | FM | FW | RV,  32'hbfc00380));
        vecs.push_back(mkv("br_now",        I_BR | I_PS,          32'h00400020, 32'h0,        RV,                      32'h00400020));
        vecs.push_back(mkv("br_not_taken",  I_BR | I_IB,          32'h00400040, 32'h0,        13'h0,                   32'h0));
        vecs.push_back(mkv("br_loaduse",    I_BR | I_PS | I_LU | I_IB, 32'h00400060, 32'h0,   SF | SD | FE,            32'h0));
        vecs.push_back(mkv("br_membusy",    I_BR | I_PS | I_MB | I_IB, 32'h00400080, 32'h0,   SF | SD | SE | SM | FW,  32'h0));
        vecs.push_back(mkv("after_nocap",   9'h0,                 32'h0,        32'h0,        13'h0,                   32'h0));
        vecs.push_back(mkv("br_busy",       I_BR | I_PS | I_IB,   32'hbfc00100, 32'h0,        13'h0,                   32'h0));
        vecs.push_back(mkv("slot_wait1",    I_IB,                 32'h0,        32'h0,        SD | FE | S1,            32'h0));
        vecs.push_back(mkv("slot_wait2",    I_IB,                 32'h0,        32'h0,        SD | FE | S1,            32'h0));
        vecs.push_back(mkv("slot_done",     I_ID,                 32'h12345678, 32'h0,        RV | S1,                 32'hbfc00100));
        vecs.push_back(mkv("slot_back_run", 9'h0,                 32'h0,        32'h0,        13'h0,                   32'h0));
        vecs.push_back(mkv("exc_busy",      I_EX | I_IB,          32'h0,        32'h11111111, SF | FD | FE | FM | FW,  32'h0));
        vecs.push_back(mkv("exc_drain",     I_IB,                 32'h0,        32'h0,        SF | FD | S2,            32'h0));
        vecs.push_back(mkv("exc_done",      I_ID,                 32'h0,        32'h0,        RV | FD | S2,            32'hbfc00380));
        vecs.push_back(mkv("exc_back_run",  9'h0,                 32'h0,        32'h0,        13'h0,                   32'h0));
        vecs.push_back(mkv("br_busy2",      I_BR | I_PS | I_IB,   32'h0000aaaa, 32'h0,        13'h0,                   32'h0));
        vecs.push_back(mkv("eret_in_slot",  I_ER,                 32'h0,        32'h80000040, FD | FE | FM | FW | RV | S1, 32'h80000040));
        vecs.push_back(mkv("slot_discard",  I_ID,                 32'h0,        32'h0,        13'h0,                   32'h0));
        vecs.push_back(mkv("br_busy3",      I_BR | I_PS | I_IB,   32'h00000bbb, 32'h0,        13'h0,                   32'h0));
        vecs.push_back(mkv("slot_membusy",  I_MB | I_IB,          32'h0,        32'h0,        SF | SD | SE | SM | FW | S1, 32'h0));
        vecs.push_back(mkv("slot_done3",    I_ID,                 32'h0,        32'h0,        RV | S1,                 32'h00000bbb));
        vecs.push_back(mkv("idle_end",      9'h0,                 32'h0,        32'h0,        13'h0,                   32'h0));

        reset = 1'b1;
        set_inputs(9'h0, 32'h0, 32'h0);
        push_exp("reset_state", 13'h0, 32'h0);
        @(negedge clock);
        check_out();
        @(posedge clock);
        #1;
        reset = 1'b0;

        foreach (vecs[k])
            step(vecs[k].name, vecs[k].in, vecs[k].tgt, vecs[k].epc, vecs[k].exp, vecs[k].pc);

        // Divider: 36 stall cycles, a memory wait in the middle must not stretch it.
        step("div_start", I_DS, 32'h0, 32'h0, SF | SD | SE | FM | DB, 32'h0);
        for (int k = 1; k < 36; k++) begin
            if (k == 10)
                step("div_membusy", I_MB, 32'h0, 32'h0, SF | SD | SE | SM | FW | DB | S3, 32'h0);
            else
                step("div_busy", 9'h0, 32'h0, 32'h0, SF | SD | SE | FM | DB | S3, 32'h0);
        end
        step("div_end", 9'h0, 32'h0, 32'h0, 13'h0, 32'h0);

        // Reset while the divider counter holds 10.
        step("div_start2", I_DS, 32'h0, 32'h0, SF | SD | SE | FM | DB, 32'h0);
        for (int k = 1; k < 26; k++)
            step("div_busy2", 9'h0, 32'h0, 32'h0, SF | SD | SE | FM | DB | S3, 32'h0);
        set_inputs(9'h0, 32'h0, 32'h0);
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        push_exp("reset_mid_div", 13'h0, 32'h0);
        @(negedge clock);
        check_out();
        @(posedge clock);
        #1;
        step("post_reset", 9'h0, 32'h0, 32'h0, 13'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
